// File: rtl/pipeline_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_if
// Bundles the hazard inputs and the per-stage control outputs of the
// pipeline stall sequencer.
//   master : pipeline side; drives hazard/status inputs and receives controls
//   slave  : stall controller side
// Signals:
//   start_i         pipeline run enable
//   mem_req_i       MEM-stage instruction accesses data memory
//   mem_ack_i       data memory access complete this cycle
//   IDEX_MemRead_i  EX-stage instruction is a load
//   IDEX_RDaddr_i   EX-stage destination register
//   IFID_RS1addr_i  ID-stage source 1
//   IFID_RS2addr_i  ID-stage source 2
//   branch_i        branch taken, resolved in ID
//   PC_en_o .. MEMWB_en_o  per-stage update enables (1 = capture)
//   IFID_flush_o    IF/ID loads NOP
//   IDEX_bubble_o   ID/EX loads zeroed control signals
//   err_o           sticky miss-timeout error
// -----------------------------------------------------------------------------
interface pipeline_stall_ctrl_if;
  logic       start_i;
  logic       mem_req_i;
  logic       mem_ack_i;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_RDaddr_i;
  logic [4:0] IFID_RS1addr_i;
  logic [4:0] IFID_RS2addr_i;
  logic       branch_i;
  logic       PC_en_o;
  logic       IFID_en_o;
  logic       IDEX_en_o;
  logic       EXMEM_en_o;
  logic       MEMWB_en_o;
  logic       IFID_flush_o;
  logic       IDEX_bubble_o;
  logic       err_o;

  modport master (
    output start_i, mem_req_i, mem_ack_i, IDEX_MemRead_i, IDEX_RDaddr_i,
           IFID_RS1addr_i, IFID_RS2addr_i, branch_i,
    input  PC_en_o, IFID_en_o, IDEX_en_o, EXMEM_en_o, MEMWB_en_o,
           IFID_flush_o, IDEX_bubble_o, err_o
  );

  modport slave (
    input  start_i, mem_req_i, mem_ack_i, IDEX_MemRead_i, IDEX_RDaddr_i,
           IFID_RS1addr_i, IFID_RS2addr_i, branch_i,
    output PC_en_o, IFID_en_o, IDEX_en_o, EXMEM_en_o, MEMWB_en_o,
           IFID_flush_o, IDEX_bubble_o, err_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
// Central hazard/stall sequencer for a 5-stage pipeline. Produces per-stage
// update enables plus IF/ID flush and ID/EX bubble controls, resolving (in
// priority order) data-memory miss, load-use hazard and taken branch.
// A miss-wait FSM (RUN / MISS_WAIT / ERR) freezes the pipe until mem_ack_i,
// with a watchdog that parks in ERR after MISS_TIMEOUT unacknowledged
// wait cycles.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous reset, active-low (also forces all controls low)
//   bus     pipeline_stall_ctrl_if.slave, hazard inputs and stage controls
//   perf_miss_o / perf_loaduse_o / perf_flush_o (only with STALL_PERF_CNT_EN)
//           saturating 32-bit cycle counters for miss freeze, bubble, flush
// Parameters:
//   MISS_TIMEOUT  max wait cycles for mem_ack_i before ERR (2..2^CNT_W-1)
//   CNT_W         width of the miss-wait counter
// Optional feature macro: STALL_PERF_CNT_EN
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int MISS_TIMEOUT = 256,
  parameter int CNT_W        = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_stall_ctrl_if.slave  bus
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]           perf_miss_o,
  output logic [31:0]           perf_loaduse_o,
  output logic [31:0]           perf_flush_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MISS_WAIT = 2'd1,
    ST_ERR       = 2'd2
  } state_t;

  // Last counter value of the wait window; no-ack there means timeout.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MISS_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_issue;      // pipe may advance this cycle (not memory-frozen)
  logic             w_load_use;
  logic             w_front_en;
  logic             w_back_en;
  logic             w_flush;
  logic             w_bubble;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign w_load_use = bus.IDEX_MemRead_i &&
                      (bus.IDEX_RDaddr_i != 5'd0) &&
                      ((bus.IDEX_RDaddr_i == bus.IFID_RS1addr_i) ||
                       (bus.IDEX_RDaddr_i == bus.IFID_RS2addr_i));

  // Next-state logic. With start_i low nothing advances: state and counter hold.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_issue      = 1'b0;
    if (bus.start_i) begin
      case (r_state)
        ST_RUN: begin
          if (bus.mem_req_i && !bus.mem_ack_i) begin
            w_state_next = ST_MISS_WAIT;
            w_cnt_next   = '0;
          end else begin
            w_issue = 1'b1;
          end
        end
        ST_MISS_WAIT: begin
          // An ack on the final wait cycle still wins over the timeout.
          if (bus.mem_ack_i) begin
            w_issue      = 1'b1;
            w_state_next = ST_RUN;
          end else if (r_cnt == LP_CNT_LAST) begin
            w_state_next = ST_ERR;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  // Load-use outranks branch: the branch is dropped during the bubble cycle
  // and re-evaluated once the dependent instruction advances.
  assign w_front_en = rst_i && w_issue && !w_load_use;
  assign w_back_en  = rst_i && w_issue;
  assign w_bubble   = rst_i && w_issue && w_load_use;
  assign w_flush    = rst_i && w_issue && !w_load_use && bus.branch_i;

  assign bus.PC_en_o       = w_front_en;
  assign bus.IFID_en_o     = w_front_en;
  assign bus.IDEX_en_o     = w_back_en;
  assign bus.EXMEM_en_o    = w_back_en;
  assign bus.MEMWB_en_o    = w_back_en;
  assign bus.IFID_flush_o  = w_flush;
  assign bus.IDEX_bubble_o = w_bubble;
  assign bus.err_o         = (r_state == ST_ERR);

`ifdef STALL_PERF_CNT_EN
  logic [2:0]       w_perf_evt;
  logic [2:0][31:0] w_perf_val;

  // Running, not in ERR and not issuing can only mean a memory freeze.
  assign w_perf_evt[0] = bus.start_i && !w_issue && (r_state != ST_ERR);
  assign w_perf_evt[1] = w_bubble;
  assign w_perf_evt[2] = w_flush;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [31:0] r_perf;
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        r_perf <= '0;
      end else if (w_perf_evt[gi] && (r_perf != 32'hFFFF_FFFF)) begin
        r_perf <= r_perf + 32'd1;
      end
    end
    assign w_perf_val[gi] = r_perf;
  end

  assign perf_miss_o    = w_perf_val[0];
  assign perf_loaduse_o = w_perf_val[1];
  assign perf_flush_o   = w_perf_val[2];
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;
  localparam int TIMEOUT = 4;
  // Output vector order: {PC, IFID, IDEX, EXMEM, MEMWB, flush, bubble, err}
  localparam logic [7:0] E_RUN = 8'b11111000;
  localparam logic [7:0] E_BR  = 8'b11111100;
  localparam logic [7:0] E_LU  = 8'b00111010;
  localparam logic [7:0] E_OFF = 8'b00000000;
  localparam logic [7:0] E_ERR = 8'b00000001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if bus();

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_miss, perf_lu, perf_fl;
`endif

  pipeline_stall_ctrl #(.MISS_TIMEOUT(TIMEOUT), .CNT_W(9)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
`ifdef STALL_PERF_CNT_EN
    ,
    .perf_miss_o    (perf_miss),
    .perf_loaduse_o (perf_lu),
    .perf_flush_o   (perf_fl)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: tracks whether a memory access is outstanding, how many
  // unacknowledged wait cycles have elapsed, and the sticky error.
  bit          m_wait, m_err;
  int          m_age;
  int unsigned m_pmiss, m_plu, m_pfl;

  function automatic void model_reset();
    m_wait = 0; m_err = 0; m_age = 0;
    m_pmiss = 0; m_plu = 0; m_pfl = 0;
  endfunction

  function automatic logic [7:0] model_exp();
    bit lu;
    lu = bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != 5'd0) &&
         (bus.IDEX_RDaddr_i == bus.IFID_RS1addr_i || bus.IDEX_RDaddr_i == bus.IFID_RS2addr_i);
    if (!rst_n) return E_OFF;
    if (m_err) return E_ERR;
    if (!bus.start_i) return E_OFF;
    if (m_wait ? !bus.mem_ack_i : (bus.mem_req_i && !bus.mem_ack_i)) return E_OFF;
    if (lu) return E_LU;
    if (bus.branch_i) return E_BR;
    return E_RUN;
  endfunction

  function automatic void model_step();
    logic [7:0] e;
    if (!rst_n) begin model_reset(); return; end
    if (m_err || !bus.start_i) return;
    e = model_exp();
    if (e == E_OFF) begin if (m_pmiss != 32'hFFFF_FFFF) m_pmiss++; end
    else if (e == E_LU) begin if (m_plu != 32'hFFFF_FFFF) m_plu++; end
    else if (e == E_BR) begin if (m_pfl != 32'hFFFF_FFFF) m_pfl++; end
    if (m_wait) begin
      if (bus.mem_ack_i) m_wait = 0;
      else begin
        m_age++;
        if (m_age == TIMEOUT) begin m_err = 1; m_wait = 0; end
      end
    end else if (bus.mem_req_i && !bus.mem_ack_i) begin
      m_wait = 1; m_age = 0;
    end
  endfunction

  function automatic logic [7:0] obs();
    return {bus.PC_en_o, bus.IFID_en_o, bus.IDEX_en_o, bus.EXMEM_en_o,
            bus.MEMWB_en_o, bus.IFID_flush_o, bus.IDEX_bubble_o, bus.err_o};
  endfunction

  task automatic set_in(input logic st, rq, ak, mr, input logic [4:0] rd, r1, r2, input logic br);
    bus.start_i = st; bus.mem_req_i = rq; bus.mem_ack_i = ak; bus.IDEX_MemRead_i = mr;
    bus.IDEX_RDaddr_i = rd; bus.IFID_RS1addr_i = r1; bus.IFID_RS2addr_i = r2; bus.branch_i = br;
  endtask

  task automatic drive(input logic st, rq, ak, mr, input logic [4:0] rd, r1, r2, input logic br);
    @(negedge clk);
    set_in(st, rq, ak, mr, rd, r1, r2, br);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    #2;
    checks++; if (obs() !== E_OFF) begin failures++; $display("FAIL reset_hold actual=%b required=%b", obs(), E_OFF); end
    tick();
    release_reset();
    checks++; if (obs() !== E_RUN) begin failures++; $display("FAIL reset_release actual=%b required=%b", obs(), E_RUN); end
    tick();
  endtask

  task automatic test_miss();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      checks++; if (obs() !== E_OFF) begin failures++; $display("FAIL miss_frozen_%0d actual=%b required=%b", i, obs(), E_OFF); end
      tick();
    end
    drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    checks++; if (obs() !== E_RUN) begin failures++; $display("FAIL miss_ack actual=%b required=%b", obs(), E_RUN); end
    tick();
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    checks++; if (obs() !== E_RUN) begin failures++; $display("FAIL miss_after actual=%b required=%b", obs(), E_RUN); end
    tick();
  endtask

  task automatic test_loaduse_branch();
    drive(1, 0, 0, 1, 5'd5, 5'd3, 5'd5, 1);
    checks++; if (obs() !== E_LU) begin failures++; $display("FAIL lu_rs2_branch actual=%b required=%b", obs(), E_LU); end
    tick();
    drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    checks++; if (obs() !== E_BR) begin failures++; $display("FAIL lu_rd0_branch actual=%b required=%b", obs(), E_BR); end
    tick();
    drive(1, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0);
    checks++; if (obs() !== E_LU) begin failures++; $display("FAIL lu_rs1 actual=%b required=%b", obs(), E_LU); end
    tick();
    drive(1, 0, 0, 0, 5'd7, 5'd7, 5'd7, 0);
    checks++; if (obs() !== E_RUN) begin failures++; $display("FAIL lu_noload actual=%b required=%b", obs(), E_RUN); end
    tick();
    drive(1, 1, 1, 1, 5'd9, 5'd1, 5'd9, 0);
    checks++; if (obs() !== E_LU) begin failures++; $display("FAIL hit_then_lu actual=%b required=%b", obs(), E_LU); end
    tick();
  endtask

  task automatic test_timeout();
    // RUN miss cycle plus TIMEOUT unacknowledged wait cycles, then ERR.
    for (int i = 0; i <= TIMEOUT; i++) begin
      drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      checks++; if (obs() !== E_OFF) begin failures++; $display("FAIL to_wait_%0d actual=%b required=%b", i, obs(), E_OFF); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(i != 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1);
      checks++; if (obs() !== E_ERR) begin failures++; $display("FAIL to_err_%0d actual=%b required=%b", i, obs(), E_ERR); end
      tick();
    end
    assert_reset();
    checks++; if (obs() !== E_OFF) begin failures++; $display("FAIL to_err_reset actual=%b required=%b", obs(), E_OFF); end
    tick();
    release_reset();
    // Ack on the last allowed wait cycle must win.
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      checks++; if (obs() !== E_OFF) begin failures++; $display("FAIL late_wait_%0d actual=%b required=%b", i, obs(), E_OFF); end
      tick();
    end
    drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    checks++; if (obs() !== E_RUN) begin failures++; $display("FAIL late_ack actual=%b required=%b", obs(), E_RUN); end
    tick();
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    checks++; if (obs() !== E_RUN) begin failures++; $display("FAIL late_ack_after actual=%b required=%b", obs(), E_RUN); end
    tick();
  endtask

  task automatic test_start_gate();
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    checks++; if (obs() !== E_BR) begin failures++; $display("FAIL start_br_on actual=%b required=%b", obs(), E_BR); end
    tick();
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    checks++; if (obs() !== E_OFF) begin failures++; $display("FAIL start_off_br actual=%b required=%b", obs(), E_OFF); end
    tick();
    // Enter MISS_WAIT, then pause: the wait counter must hold while start_i=0.
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1);
      tick();
    end
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      checks++; if (obs() !== E_OFF) begin failures++; $display("FAIL start_hold_wait_%0d actual=%b required=%b", i, obs(), E_OFF); end
      tick();
    end
    drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    checks++; if (obs() !== E_RUN) begin failures++; $display("FAIL start_hold_ack actual=%b required=%b", obs(), E_RUN); end
    tick();
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    checks++; if (obs() !== E_BR) begin failures++; $display("FAIL start_resume_br actual=%b required=%b", obs(), E_BR); end
    tick();
  endtask

  task automatic test_reset_mid_miss();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      tick();
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (obs() !== E_OFF) begin failures++; $display("FAIL midmiss_reset actual=%b required=%b", obs(), E_OFF); end
    tick();
    release_reset();
    checks++; if (obs() !== E_RUN) begin failures++; $display("FAIL midmiss_release actual=%b required=%b", obs(), E_RUN); end
    tick();
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    checks++; if (obs() !== E_RUN) begin failures++; $display("FAIL midmiss_run actual=%b required=%b", obs(), E_RUN); end
    tick();
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic do_miss(input int waits);
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    for (int i = 0; i < waits; i++) begin
      drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      tick();
    end
    drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
  endtask

  task automatic test_perf();
    assert_reset();
    checks++; if (perf_miss !== 32'd0) begin failures++; $display("FAIL perf_rst_miss actual=%0d required=0", perf_miss); end
    checks++; if (perf_lu !== 32'd0) begin failures++; $display("FAIL perf_rst_lu actual=%0d required=0", perf_lu); end
    checks++; if (perf_fl !== 32'd0) begin failures++; $display("FAIL perf_rst_fl actual=%0d required=0", perf_fl); end
    tick();
    release_reset();
    do_miss(3);   // 4 frozen cycles
    do_miss(3);   // 4 frozen cycles
    do_miss(1);   // 2 frozen cycles
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1);  // paused: nothing counted
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    tick();
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    checks++; if (perf_miss !== 32'd10) begin failures++; $display("FAIL perf_miss actual=%0d required=10", perf_miss); end
    checks++; if (perf_lu !== 32'd2) begin failures++; $display("FAIL perf_loaduse actual=%0d required=2", perf_lu); end
    checks++; if (perf_fl !== 32'd1) begin failures++; $display("FAIL perf_flush actual=%0d required=1", perf_fl); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [7:0] e;
    assert_reset();
    tick();
    release_reset();
    for (int i = 0; i < 400; i++) begin
      if ((!m_err && $urandom_range(0, 39) == 0) || (m_err && $urandom_range(0, 3) == 0)) begin
        assert_reset();
        checks++; if (obs() !== E_OFF) begin failures++; $display("FAIL rnd_reset_%0d actual=%b required=%b", i, obs(), E_OFF); end
        tick();
        release_reset();
      end
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 4, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 9) < 3);
      e = model_exp();
      checks++; if (obs() !== e) begin failures++; $display("FAIL rnd_out_%0d actual=%b required=%b", i, obs(), e); end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (perf_miss !== m_pmiss || perf_lu !== m_plu || perf_fl !== m_pfl) begin
        failures++;
        $display("FAIL rnd_perf_%0d actual=%0d/%0d/%0d required=%0d/%0d/%0d", i,
                 perf_miss, perf_lu, perf_fl, m_pmiss, m_plu, m_pfl);
      end
`endif
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_miss();
    test_loaduse_branch();
    test_timeout();
    test_start_gate();
    test_reset_mid_miss();
`ifdef STALL_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage pipeline. Generates per-stage update enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus flush and bubble controls. Resolves three sources: data-memory miss (freeze whole pipe), load-use hazard (stall front, bubble ID/EX) and taken branch (flush IF/ID). Contains a miss-wait FSM with timeout watchdog.

Parameters:
MISS_TIMEOUT, 256, max wait cycles for mem_ack_i before entering ERR; legal range 2..2^CNT_W-1
CNT_W, 9, width of miss-wait counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
start_i  input  1  pipeline run enable; 0 forces all enables to 0
mem_req_i  input  1  MEM-stage instruction accesses data memory (MemRead|MemWrite from EX/MEM)
mem_ack_i  input  1  data memory access complete this cycle
IDEX_MemRead_i  input  1  EX-stage instruction is a load
IDEX_RDaddr_i  input  5  EX-stage destination register
IFID_RS1addr_i  input  5  ID-stage source 1
IFID_RS2addr_i  input  5  ID-stage source 2
branch_i  input  1  branch taken, resolved in ID
PC_en_o  output  1  PC update enable
IFID_en_o  output  1  IF/ID update enable
IDEX_en_o  output  1  ID/EX update enable
EXMEM_en_o  output  1  EX/MEM update enable
MEMWB_en_o  output  1  MEM/WB update enable
IFID_flush_o  output  1  IF/ID loads NOP
IDEX_bubble_o  output  1  ID/EX loads zeroed control signals
err_o  output  1  sticky miss-timeout error

Behaviour:
- Enables are active-high: 1 = register captures its input, 0 = holds.
- States: RUN, MISS_WAIT, ERR. Reset (rst_i=0): state RUN, counter 0, err_o 0. Reset is immediate, including mid-MISS_WAIT and in ERR.
- Outputs combinational from state and inputs. While rst_i=0 or start_i=0: all enables 0, flush 0, bubble 0. FSM holds state while start_i=0.
- Priority in RUN (highest first): memory stall, load-use, branch.
- RUN, mem_req_i=1 and mem_ack_i=0: all enables 0, flush/bubble 0. Next state MISS_WAIT, counter cleared to 0.
- RUN, mem_req_i=1 and mem_ack_i=1 (hit): zero stall; fall through to load-use/branch checks.
- Load-use: IDEX_MemRead_i=1, IDEX_RDaddr_i!=0, and IDEX_RDaddr_i equals RS1 or RS2. Response: PC_en_o=0, IFID_en_o=0, IDEX_bubble_o=1, IDEX/EXMEM/MEMWB enables 1. branch_i ignored this cycle; branch is re-evaluated after the stall.
- Branch (no stall): all enables 1, IFID_flush_o=1.
- Otherwise: all enables 1, flush/bubble 0.
- MISS_WAIT: all enables 0, counter increments each cycle.
  - On mem_ack_i=1: enables 1 in the same cycle, with load-use/branch rules applied as in RUN. Next state RUN.
  - If counter reaches MISS_TIMEOUT-1 with no ack: next state ERR.
  - An ack arriving in that same cycle wins; no error is raised.
- ERR: err_o=1, all enables 0. Exit only by reset.
- Counter never wraps; it is bounded by the timeout.

Optional Feature:
STALL_PERF_CNT_EN: adds outputs perf_miss_o, perf_loaduse_o, perf_flush_o (32 bits each).
- Each counts cycles spent in the respective condition: miss = enables frozen by memory; loaduse = bubble cycles; flush = flush cycles.
- Counters saturate at 0xFFFFFFFF, reset to 0, and do not count while start_i=0.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-MISS_WAIT (counter=5): drop rst_i -> all enables 0 immediately; after release with start_i=1 and no hazards, all enables 1 and state RUN.
- mem_req_i=1, ack held low 3 cycles then high -> enables 0 for 3 cycles (RUN cycle + 2 MISS_WAIT), all 1 on the ack cycle, err_o stays 0.
- IDEX_MemRead_i=1, IDEX_RDaddr_i=5, RS2=5, branch_i=1 -> PC_en_o=0, IFID_en_o=0, IDEX_bubble_o=1, IFID_flush_o=0. Repeat with RDaddr=0 -> no stall, IFID_flush_o=1.
- MISS_TIMEOUT=4, req with ack never asserted -> err_o=1 after 4 wait cycles and stays 1. Ack arriving exactly on the timeout cycle instead -> returns to RUN, err_o=0.
- start_i=0 during RUN with branch_i=1 -> all outputs 0; restoring start_i resumes normal flush behaviour.
- With STALL_PERF_CNT_EN: 10-cycle miss plus 2 load-use stalls -> perf_miss_o=10, perf_loaduse_o=2.
